// File: rtl/fir_output_writer.sv
// fir_output_writer: write-side engine for the FIR result region.
// Takes the filtered-sample stream, buffers it in a small FIFO and writes it
// to sample memory at base_addr + n (modulo 2^ADDR_W) through an arbitrated
// write port. It flags completion with a held done and counts the busy cycles
// of each run.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle run request (accepted in IDLE/DONE only)
//   base_addr            first write address, latched on accepted start
//   sample_count         samples to write, latched on accepted start
//   in_valid/in_data     sample stream from the FIR datapath
//   in_ready             writer accepts a sample this cycle
//   mem_we/addr/wdata    write request, held stable until granted
//   mem_gnt              arbiter grant; a write retires on mem_we && mem_gnt
//   busy, done           run in progress / run complete (held)
//   cycle_count          busy cycles of the last or current run (saturating)
module fir_output_writer #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] sample_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] head_d;

    logic              in_ready_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              busy_d;
    logic              done_d;
    logic [CNT_W-1:0]  cycle_d;

    logic              push_c;
    logic              pop_c;

    assign push_c = in_valid && in_ready;
    assign pop_c  = mem_we && mem_gnt;

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q + ADDR_W'(push_c);
        wr_d        = wr_q + ADDR_W'(pop_c);
        wr_ptr_d    = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_c);
        level_d     = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
        cycle_d     = cycle_count;
        in_ready_d  = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        // A sample pushed into the slot that becomes the head bypasses storage.
        if (push_c && (wr_ptr_q == rd_ptr_d)) begin
            head_d = in_data;
        end else begin
            head_d = fifo_mem[rd_ptr_d];
        end

        if (((state_q == S_RUN) || (state_q == S_DRAIN)) && (cycle_count != '1)) begin
            cycle_d = cycle_count + CNT_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    base_d  = base_addr;
                    cnt_d   = sample_count;
                    acc_d   = '0;
                    wr_d    = '0;
                    cycle_d = '0;
                end
            end
            S_RUN: begin
                if (acc_d == cnt_q) begin
                    state_d = (wr_d == cnt_q) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (wr_d == cnt_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Full level blocks input even when a pop retires in the same cycle.
        in_ready_d = (state_d == S_RUN) && (level_d < LVL_W'(FIFO_DEPTH)) && (acc_d < cnt_d);
        busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d     = (state_d == S_DONE);
        mem_we_d   = busy_d && (level_d != '0);

        // Address/data only move when a write is pending; otherwise they hold.
        if (mem_we_d) begin
            mem_addr_d  = base_d + wr_d;
            mem_wdata_d = head_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            wr_q        <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            in_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            wr_q        <= wr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            in_ready    <= in_ready_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            busy        <= busy_d;
            done        <= done_d;
            cycle_count <= cycle_d;
        end
    end

    // FIFO storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_fir_output_writer.sv
// Bench for fir_output_writer: randomized stream/grant stimulus checked every
// cycle against a count-based run model, plus a memory image checked per run.
module tb_fir_output_writer;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] sample_count = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycle_count;

    fir_output_writer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .sample_count(sample_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .busy(busy), .done(done),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Run model: a run is the count of accepted and written samples.
    logic          m_run = 1'b0;
    logic          m_done = 1'b0;
    logic [AW-1:0] m_base = '0;
    logic [AW-1:0] m_cnt = '0;
    logic [AW-1:0] m_acc = '0;
    logic [AW-1:0] m_wr = '0;
    logic [CW-1:0] m_cyc = '0;
    logic          m_push = 1'b0;
    logic          prev_stall = 1'b0;
    logic          prev_done = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    logic          saw_full = 1'b0;
    logic [DW-1:0] stim [1024];
    logic [DW-1:0] dmem [1024];
    int            wcnt [1024];
    int            n_writes = 0;
    int            done_rises = 0;

    logic          push_obs, pop_obs;
    logic [AW-1:0] na, nw, lvl;
    assign push_obs = in_valid && in_ready;
    assign pop_obs  = mem_we && mem_gnt;
    assign na       = m_acc + AW'(push_obs);
    assign nw       = m_wr + AW'(pop_obs);
    assign lvl      = m_acc - m_wr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run      <= 1'b0;
            m_done     <= 1'b0;
            m_acc      <= '0;
            m_wr       <= '0;
            m_cyc      <= '0;
            m_push     <= 1'b0;
            prev_stall <= 1'b0;
            prev_done  <= 1'b0;
        end else begin
            m_push     <= push_obs;
            prev_stall <= mem_we && !mem_gnt;
            prev_addr  <= mem_addr;
            prev_data  <= mem_wdata;
            prev_done  <= done;
            if (done && !prev_done) done_rises <= done_rises + 1;
            if (pop_obs) begin
                dmem[mem_addr] <= mem_wdata;
                wcnt[mem_addr] <= wcnt[mem_addr] + 1;
                n_writes       <= n_writes + 1;
            end
            if (m_run) begin
                m_cyc <= m_cyc + CW'(1);
                m_acc <= na;
                m_wr  <= nw;
                if ((na == m_cnt) && (nw == m_cnt)) begin
                    m_run  <= 1'b0;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                m_run      <= 1'b1;
                m_done     <= 1'b0;
                m_base     <= base_addr;
                m_cnt      <= sample_count;
                m_acc      <= '0;
                m_wr       <= '0;
                m_cyc      <= '0;
                n_writes   <= 0;
                done_rises <= 0;
                for (int i = 0; i < 1024; i++) wcnt[i] <= 0;
            end
        end
    end

    // Per-cycle compare on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 64'(in_ready),
                64'(m_run && (m_acc < m_cnt) && (lvl < AW'(4))));
            chk("mem_we", 64'(mem_we), 64'(m_run && (lvl != '0)));
            chk("busy", 64'(busy), 64'(m_run));
            chk("done", 64'(done), 64'(m_done));
            chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
            if (m_run && (lvl != '0)) begin
                chk("mem_addr", 64'(mem_addr), 64'(AW'(m_base + m_wr)));
                chk("mem_wdata", 64'(mem_wdata), 64'(stim[m_wr]));
            end
            if (prev_stall) begin
                chk("addr_stable", 64'(mem_addr), 64'(prev_addr));
                chk("wdata_stable", 64'(mem_wdata), 64'(prev_data));
            end
            if (lvl == AW'(4)) saw_full <= 1'b1;
        end
    end

    // vmode: 0 continuous, 1 random 50%. gmode: 0 tied, 1 one-on-three-off, 2 random.
    // dmode: 0 data=i, 1 -40/+40 split, 2 random.
    task automatic run(input logic [AW-1:0] base, input logic [AW-1:0] cnt,
                       input int vmode, input int gmode, input int dmode,
                       input bit spur, input int abort_at);
        int  cyc;
        bit  aborted;
        logic [AW-1:0] a;
        for (int i = 0; i < 1024; i++) begin
            if (dmode == 0) stim[i] = DW'(i);
            else if (dmode == 1) stim[i] = (i < 50) ? 8'hD8 : 8'h28;
            else stim[i] = DW'($urandom);
        end
        aborted = 1'b0;
        @(posedge clk); #1;
        base_addr    = base;
        sample_count = cnt;
        start        = 1'b1;
        in_valid     = 1'b0;
        mem_gnt      = 1'b1;
        cyc          = 0;
        forever begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc   = cyc + 1;
            if (m_done) break;
            if (cyc > 3000) begin
                chk("run_timeout", 64'(0), 64'(1));
                break;
            end
            if ((abort_at > 0) && (int'(m_acc) == abort_at)) begin
                rst_n = 1'b0;
                #1;
                chk("rst_in_ready", 64'(in_ready), 64'(0));
                chk("rst_mem_we", 64'(mem_we), 64'(0));
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_done", 64'(done), 64'(0));
                chk("rst_mem_addr", 64'(mem_addr), 64'(0));
                chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
                chk("rst_cycle_count", 64'(cycle_count), 64'(0));
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_no_we", 64'(mem_we), 64'(0));
                end
                in_valid = 1'b0;
                #2 rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (spur && (cyc == 10)) begin
                start        = 1'b1;
                base_addr    = ~base;
                sample_count = AW'(3);
            end
            if (!in_valid || m_push) begin
                if (m_acc >= cnt) in_valid = 1'b0;
                else if (vmode == 0) in_valid = 1'b1;
                else in_valid = ($urandom_range(1, 0) == 1);
            end
            in_data = stim[m_acc];
            if (gmode == 0) mem_gnt = 1'b1;
            else if (gmode == 1) mem_gnt = ((cyc % 4) == 0);
            else mem_gnt = ($urandom_range(1, 0) == 1);
        end
        in_valid = 1'b0;
        mem_gnt  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (!aborted) begin
            for (int i = 0; i < int'(cnt); i++) begin
                a = base + AW'(i);
                chk("mem_image", 64'(dmem[a]), 64'(stim[i]));
                chk("write_once", 64'(wcnt[a]), 64'(1));
            end
            chk("n_writes", 64'(n_writes), 64'(cnt));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'(0));
        chk("reset_mem_we", 64'(mem_we), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_mem_addr", 64'(mem_addr), 64'(0));
        chk("reset_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("reset_cycle_count", 64'(cycle_count), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic run
        run(AW'(512), AW'(100), 0, 0, 0, 1'b0, 0);
        chk("basic_cycles", 64'(cycle_count), 64'(101));
        chk("basic_done", 64'(done), 64'(1));
        chk("basic_last", 64'(dmem[611]), 64'(8'h63));
        repeat (5) @(posedge clk);
        #1 chk("basic_done_held", 64'(done), 64'(1));

        // Backpressure
        run(AW'(512), AW'(100), 0, 1, 0, 1'b0, 0);
        chk("bp_saw_full", 64'(saw_full), 64'(1));

        // Bursty source, signed data
        run(AW'(512), AW'(100), 1, 2, 1, 1'b0, 0);
        chk("neg_first", 64'(dmem[512]), 64'(8'hD8));
        chk("pos_later", 64'(dmem[611]), 64'(8'h28));
        chk("done_once", 64'(done_rises), 64'(1));

        // Zero count
        run(AW'(512), AW'(0), 0, 0, 0, 1'b0, 0);
        chk("zero_cycles", 64'(cycle_count), 64'(1));
        chk("zero_writes", 64'(n_writes), 64'(0));

        // Address wrap
        run(AW'(1020), AW'(8), 1, 2, 2, 1'b0, 0);
        chk("wrap_slot0", 64'(dmem[0]), 64'(stim[4]));
        chk("wrap_1023", 64'(wcnt[1023]), 64'(1));

        // Start during run ignored
        run(AW'(100), AW'(30), 1, 2, 2, 1'b1, 0);
        chk("spur_writes", 64'(n_writes), 64'(30));

        // Reset mid-run, then a clean run
        run(AW'(512), AW'(100), 0, 0, 0, 1'b0, 37);
        run(AW'(300), AW'(10), 0, 0, 2, 1'b0, 0);

        // Back-to-back from DONE
        run(AW'(0), AW'(20), 1, 2, 2, 1'b0, 0);
        chk("b2b_cycles_ge", 64'(cycle_count >= 21), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
